// File: rtl/video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// video_timing_analyzer
//
// Measures the raster geometry of a sync/DE video stream and publishes it
// once per frame, together with a stability indication.
//
// Parameters
//   CNT_W          width of every pixel/line counter and measurement output
//   STABLE_FRAMES  identical consecutive publishes needed before valid (1..15)
//
// Ports
//   CLK_VIDEO    in   video clock
//   reset_n      in   synchronous active-low reset
//   CE_PIXEL     in   pixel clock enable; all video inputs sampled only here
//   VGA_HS       in   horizontal sync, positive pulse
//   VGA_VS       in   vertical sync, positive pulse
//   VGA_DE       in   display enable
//   h_total      out  pixels per line
//   h_active     out  active pixels per line
//   v_total      out  lines per frame
//   v_active     out  lines holding at least one active pixel
//   valid        out  measurements identical for STABLE_FRAMES publishes
//   changed      out  one-clock pulse when a publish differs from the last
//   frame_pulse  out  one-clock pulse on every publish
// ---------------------------------------------------------------------------
module video_timing_analyzer #(
    parameter int CNT_W         = 12,
    parameter int STABLE_FRAMES = 2
) (
    input  logic             CLK_VIDEO,
    input  logic             reset_n,
    input  logic             CE_PIXEL,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic             VGA_DE,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             valid,
    output logic             changed,
    output logic             frame_pulse
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
    // One below all-ones: a counter about to step onto all-ones is an overflow,
    // so the counters themselves never hold or pass the top value.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((2 ** CNT_W) - 2);
    localparam logic [3:0]       STABLE_MAX = 4'(STABLE_FRAMES);

    state_t           state_q, state_d;
    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] de_cnt_q, de_cnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] line_act_q, line_act_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic [CNT_W-1:0] h_total_q, h_total_d;
    logic [CNT_W-1:0] h_active_q, h_active_d;
    logic [CNT_W-1:0] v_total_q, v_total_d;
    logic [CNT_W-1:0] v_active_q, v_active_d;
    logic [3:0]       stable_cnt_q, stable_cnt_d;
    logic             first_q, first_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             frame_pulse_q, frame_pulse_d;

    logic             hs_edge, vs_edge, ovf, line_has_de, same_meas;
    logic [CNT_W-1:0] line_value;
    logic [CNT_W-1:0] pix_n, de_n, len_n, lact_n, lcnt_n, acnt_n;
    logic [CNT_W-1:0] pub_ht, pub_ha, pub_vt, pub_va;

    assign hs_edge     = CE_PIXEL & VGA_HS & ~hs_prev_q;
    assign vs_edge     = CE_PIXEL & VGA_VS & ~vs_prev_q;
    // DE count of the line closing on this CE, including the current pixel
    assign line_value  = de_cnt_q + {{(CNT_W-1){1'b0}}, VGA_DE};
    assign line_has_de = (line_value != '0);

    // Snapshot for a frame closing on this CE. A coincident HS edge still
    // latches its line length first, but the line it opens belongs to the
    // next frame, so the line counters are taken before that edge.
    assign pub_ht = hs_edge ? (pix_cnt_q + ONE) : line_len_q;
    assign pub_ha = (hs_edge && line_has_de) ? line_value : line_act_q;
    assign pub_vt = line_cnt_q;
    assign pub_va = act_cnt_q;

    assign same_meas = (pub_ht == h_total_q) && (pub_ha == h_active_q) &&
                       (pub_vt == v_total_q) && (pub_va == v_active_q);

    assign ovf = CE_PIXEL && ((!hs_edge && (pix_cnt_q == CNT_LAST)) ||
                              (hs_edge && !vs_edge && (line_cnt_q == CNT_LAST)));

    // Counter next-values as if measuring; the FSM decides whether to keep them.
    always_comb begin
        pix_n  = pix_cnt_q;
        de_n   = de_cnt_q;
        len_n  = line_len_q;
        lact_n = line_act_q;
        lcnt_n = line_cnt_q;
        acnt_n = act_cnt_q;
        if (hs_edge) begin
            len_n  = pix_cnt_q + ONE;
            pix_n  = '0;
            de_n   = '0;
            lcnt_n = line_cnt_q + ONE;
            if (line_has_de) begin
                lact_n = line_value;
                acnt_n = act_cnt_q + ONE;
            end
        end else if (CE_PIXEL) begin
            pix_n = pix_cnt_q + ONE;
            if (VGA_DE) begin
                de_n = de_cnt_q + ONE;
            end
        end
        if (vs_edge) begin
            // New frame: per-frame line results restart; a coincident HS
            // edge is the first line of the new frame.
            len_n  = '0;
            lact_n = '0;
            lcnt_n = hs_edge ? ONE : '0;
            acnt_n = (hs_edge && line_has_de) ? ONE : '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        pix_cnt_d     = pix_cnt_q;
        de_cnt_d      = de_cnt_q;
        line_len_d    = line_len_q;
        line_act_d    = line_act_q;
        line_cnt_d    = line_cnt_q;
        act_cnt_d     = act_cnt_q;
        h_total_d     = h_total_q;
        h_active_d    = h_active_q;
        v_total_d     = v_total_q;
        v_active_d    = v_active_q;
        stable_cnt_d  = stable_cnt_q;
        first_d       = first_q;
        valid_d       = valid_q;
        changed_d     = 1'b0;
        frame_pulse_d = 1'b0;

        if (CE_PIXEL) begin
            hs_prev_d = VGA_HS;
            vs_prev_d = VGA_VS;
            if (state_q == IDLE) begin
                if (vs_edge) begin
                    // Partial frame before this edge is discarded.
                    state_d    = MEASURE;
                    first_d    = 1'b1;
                    pix_cnt_d  = pix_n;
                    de_cnt_d   = de_n;
                    line_len_d = len_n;
                    line_act_d = lact_n;
                    line_cnt_d = lcnt_n;
                    act_cnt_d  = acnt_n;
                end else begin
                    pix_cnt_d  = '0;
                    de_cnt_d   = '0;
                    line_len_d = '0;
                    line_act_d = '0;
                    line_cnt_d = '0;
                    act_cnt_d  = '0;
                end
            end else if (ovf) begin
                state_d      = IDLE;
                pix_cnt_d    = '0;
                de_cnt_d     = '0;
                line_len_d   = '0;
                line_act_d   = '0;
                line_cnt_d   = '0;
                act_cnt_d    = '0;
                stable_cnt_d = '0;
                valid_d      = 1'b0;
            end else begin
                pix_cnt_d  = pix_n;
                de_cnt_d   = de_n;
                line_len_d = len_n;
                line_act_d = lact_n;
                line_cnt_d = lcnt_n;
                act_cnt_d  = acnt_n;
                if (vs_edge) begin
                    h_total_d     = pub_ht;
                    h_active_d    = pub_ha;
                    v_total_d     = pub_vt;
                    v_active_d    = pub_va;
                    frame_pulse_d = 1'b1;
                    first_d       = 1'b0;
                    if (first_q || !same_meas) begin
                        stable_cnt_d = '0;
                        changed_d    = 1'b1;
                    end else if (stable_cnt_q != STABLE_MAX) begin
                        stable_cnt_d = stable_cnt_q + 4'd1;
                    end
                    valid_d = (stable_cnt_d == STABLE_MAX);
                end
            end
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            pix_cnt_q     <= '0;
            de_cnt_q      <= '0;
            line_len_q    <= '0;
            line_act_q    <= '0;
            line_cnt_q    <= '0;
            act_cnt_q     <= '0;
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            stable_cnt_q  <= '0;
            first_q       <= 1'b0;
            valid_q       <= 1'b0;
            changed_q     <= 1'b0;
            frame_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            pix_cnt_q     <= pix_cnt_d;
            de_cnt_q      <= de_cnt_d;
            line_len_q    <= line_len_d;
            line_act_q    <= line_act_d;
            line_cnt_q    <= line_cnt_d;
            act_cnt_q     <= act_cnt_d;
            h_total_q     <= h_total_d;
            h_active_q    <= h_active_d;
            v_total_q     <= v_total_d;
            v_active_q    <= v_active_d;
            stable_cnt_q  <= stable_cnt_d;
            first_q       <= first_d;
            valid_q       <= valid_d;
            changed_q     <= changed_d;
            frame_pulse_q <= frame_pulse_d;
        end
    end

    assign h_total     = h_total_q;
    assign h_active    = h_active_q;
    assign v_total     = v_total_q;
    assign v_active    = v_active_q;
    assign valid       = valid_q;
    assign changed     = changed_q;
    assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_video_timing_analyzer.sv
// ---------------------------------------------------------------------------
// tb_video_timing_analyzer
//
// Scoreboard bench. Each time a frame-opening VS is driven, the expected
// publish of the frame it closes is pushed to a queue; every frame_pulse
// pops one entry and compares all published fields. Raster formats are
// scaled down so the run stays short.
// ---------------------------------------------------------------------------
module tb_video_timing_analyzer;
    localparam int CNT_W  = 12;
    localparam int STABLE = 2;
    localparam int CE_DIV = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             ce = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
    logic             valid, changed, frame_pulse;

    video_timing_analyzer #(.CNT_W(CNT_W), .STABLE_FRAMES(STABLE)) dut (
        .CLK_VIDEO(clk), .reset_n(reset_n), .CE_PIXEL(ce),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_DE(de),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .valid(valid), .changed(changed), .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ht, ha, vt, va;
        bit chg, vld;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   miscmp_cnt = 0;
    int   pub_cnt = 0;

    // Reference model of the publish sequence
    bit   armed = 1'b0;
    bit   m_first = 1'b1;
    int   m_stable = 0;
    int   m_prev[4];
    int   o_own = 0, o_ht = 0, o_ha = 0, o_va = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called as the VS edge of a new frame is driven. pre_hs: new frame's
    // first HS edge precedes its VS (it then closes the old frame's count).
    // own: HS edges counted inside the new frame itself.
    task automatic frame_start(input int pre_hs, input int own, input int ht, input int ha, input int va);
        exp_t e;
        bit   same;
        if (armed) begin
            e.ht = o_ht; e.ha = o_ha; e.vt = o_own + pre_hs; e.va = o_va;
            same = !m_first && e.ht == m_prev[0] && e.ha == m_prev[1] &&
                   e.vt == m_prev[2] && e.va == m_prev[3];
            if (same) m_stable = (m_stable < STABLE) ? m_stable + 1 : m_stable;
            else      m_stable = 0;
            e.chg = !same;
            e.vld = (m_stable == STABLE);
            m_prev[0] = e.ht; m_prev[1] = e.ha; m_prev[2] = e.vt; m_prev[3] = e.va;
            m_first = 1'b0;
            exp_q.push_back(e);
        end else begin
            m_first = 1'b1;
        end
        armed = 1'b1;
        o_own = own; o_ht = ht; o_ha = ha; o_va = va;
    endtask

    // div-1 idle clocks with junk on the video inputs, then one CE clock
    task automatic tick(input logic h, input logic v, input logic d, input int div);
        for (int k = 0; k < div - 1; k++) begin
            ce = 1'b0; hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ce = 1'b1; hs = h; vs = v; de = d;
        @(posedge clk); #1;
    endtask

    task automatic mid_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_val("rst_h_total", h_total, 0);
        check_val("rst_h_active", h_active, 0);
        check_val("rst_v_total", v_total, 0);
        check_val("rst_v_active", v_active, 0);
        check_val("rst_valid", valid, 0);
        check_val("rst_changed", changed, 0);
        check_val("rst_frame_pulse", frame_pulse, 0);
        reset_n = 1'b1;
        armed = 1'b0;
    endtask

    // HS on pixels 0-1, DE on pixels 2..ha+1 of lines 1..va, VS on line 0
    // (from pixel 1, or from pixel 0 coincident with HS when co=1).
    task automatic run_frame(input int ht, input int ha, input int vt, input int va,
                             input bit co, input int stall_line);
        for (int l = 0; l < vt; l++) begin
            for (int p = 0; p < ht; p++) begin
                if (l == 0 && p == (co ? 0 : 1))
                    frame_start(co ? 0 : 1, co ? vt : vt - 1, ht, ha, va);
                tick(p < 2, (l == 0) && (co || p >= 1),
                     (l >= 1) && (l <= va) && (p >= 2) && (p < 2 + ha), CE_DIV);
                if (l == stall_line && p == 5) begin
                    ce = 1'b0;
                    repeat (1000) begin
                        hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
                        @(posedge clk); #1;
                    end
                end
            end
        end
    endtask

    // Frame with VS pulses but no HS edges at all
    task automatic run_vs_only(input int n, input int rst_at);
        for (int c = 0; c < n; c++) begin
            if (c == 0) frame_start(0, 0, 0, 0, 0);
            tick(1'b0, c < 2, (c % 3) == 0, CE_DIV);
            if (c == rst_at) mid_reset();
        end
    endtask

    // Short lines with CE every clock and no VS: drives the line counter
    // into overflow.
    task automatic long_lines(input int n);
        for (int l = 0; l < n; l++)
            for (int p = 0; p < 6; p++)
                tick(p < 2, 1'b0, (p >= 2) && (p < 4), 1);
        armed = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n) begin
            if (frame_pulse) begin
                pub_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("spurious_pub", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("pub %0d: h_total=%0d h_active=%0d v_total=%0d v_active=%0d changed=%0b valid=%0b (exp %0d/%0d/%0d/%0d %0b %0b)",
                             pub_cnt, h_total, h_active, v_total, v_active, changed, valid,
                             e.ht, e.ha, e.vt, e.va, e.chg, e.vld);
                    check_val("h_total", h_total, e.ht);
                    check_val("h_active", h_active, e.ha);
                    check_val("v_total", v_total, e.vt);
                    check_val("v_active", v_active, e.va);
                    check_val("changed", changed, e.chg);
                    check_val("valid", valid, e.vld);
                end
            end else if (changed) begin
                check_val("changed_without_pub", changed, 0);
            end
        end
    end

    initial begin : watchdog
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_h_total", h_total, 0);
        check_val("reset_v_total", v_total, 0);
        check_val("reset_valid", valid, 0);
        check_val("reset_frame_pulse", frame_pulse, 0);
        reset_n = 1'b1;

        // 24x10 raster, 16x8 active: lock and reach valid
        for (int f = 0; f < 4; f++) run_frame(24, 16, 10, 8, 1'b0, -1);
        // switch to a 26-pixel line with 20 active, one frame with a CE stall
        for (int f = 0; f < 4; f++) run_frame(26, 20, 10, 8, 1'b0, (f == 2) ? 4 : -1);
        // line counter overflow without VS
        long_lines(4100);
        repeat (3) @(posedge clk);
        #1;
        check_val("ovf_valid", valid, 0);
        check_val("ovf_hold_h_total", h_total, 26);
        check_val("ovf_hold_h_active", h_active, 20);
        check_val("ovf_hold_v_total", v_total, 10);
        // recovery, then HS/VS coincident frames
        for (int f = 0; f < 3; f++) run_frame(24, 16, 10, 8, 1'b0, -1);
        for (int f = 0; f < 4; f++) run_frame(24, 16, 10, 8, 1'b1, -1);
        // frames without HS publish zero horizontal geometry
        for (int f = 0; f < 4; f++) run_vs_only(40, -1);
        check_val("pre_reset_valid", valid, 1);
        run_vs_only(40, 5);
        for (int f = 0; f < 3; f++) run_frame(24, 16, 10, 8, 1'b0, -1);

        ce = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_val("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end
endmodule
